// File: rtl/opcode_tag_allocator_pkg.sv
// Shared opcode-type, tag and encoding definitions for tag allocators and encoders.
// Combinational helpers only; no state.
// No flow control here; callers own handshakes.
package opcode_tag_allocator_pkg;

    localparam int NUM_TYPES_DEF = 5;
    localparam int TAG_W_DEF     = 9;
    localparam int MAX_TAGS_DEF  = 64;

    typedef enum logic [2:0] {
        OP_T0 = 3'd0,
        OP_T1 = 3'd1,
        OP_T2 = 3'd2,
        OP_T3 = 3'd3,
        OP_T4 = 3'd4
    } opcode_type_e;

    typedef logic [TAG_W_DEF-1:0] tag_t;
    typedef logic [NUM_TYPES_DEF-1:0][TAG_W_DEF-1:0] enc_tbl_t;

    // Element [t] is opcode type t.
    localparam enc_tbl_t ENC_VALUE_DEF = {9'h100, 9'h0c0, 9'h080, 9'h040, 9'h000};
    localparam enc_tbl_t ENC_MASK_DEF  = {9'h1fe, 9'h1c0, 9'h1c0, 9'h1c0, 9'h1c0};

    typedef struct packed {
        logic         hit;
        opcode_type_e typ;
        tag_t         idx;
    } dec_t;

    // Lowest matching type wins, so the scan runs high to low and keeps the last hit.
    function automatic dec_t decode_tag(input tag_t tag, input enc_tbl_t val, input enc_tbl_t mask);
        dec_t d;
        d.hit = 1'b0;
        d.typ = OP_T0;
        d.idx = '0;
        for (int t = NUM_TYPES_DEF - 1; t >= 0; t--) begin
            if ((tag & mask[t]) == val[t]) begin
                d.hit = 1'b1;
                d.typ = opcode_type_e'(3'(t));
                d.idx = tag & ~mask[t];
            end
        end
        return d;
    endfunction

    function automatic int pool_cap(input tag_t mask, input int max_tags);
        int zeros;
        zeros = 0;
        for (int i = 0; i < TAG_W_DEF; i++) begin
            if (!mask[i]) zeros++;
        end
        if (zeros >= 30) return max_tags;
        return ((1 << zeros) < max_tags) ? (1 << zeros) : max_tags;
    endfunction

endpackage

// File: rtl/opcode_tag_allocator_tag_pool.sv
// Per-type tag pool: in-use bitmap, lowest-free search, set/clear and population count.
// ready/alloc_idx/free_hit are combinational; bitmap and count update on the clock edge.
// No backpressure; the parent only asserts alloc_en when ready is high.
module opcode_tag_allocator_tag_pool #(
    parameter int MAX_TAGS = 64,
    parameter int CAP      = 64,
    parameter int IDX_W    = $clog2(MAX_TAGS),
    parameter int CNT_W    = $clog2(MAX_TAGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic             free_en,
    input  logic [IDX_W-1:0] free_idx,
    output logic             ready,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             free_hit,
    output logic [CNT_W-1:0] count
);

    logic [MAX_TAGS-1:0] bitmap;

    // Only indices below CAP are searched, so bits at or above CAP stay clear.
    always_comb begin
        ready     = 1'b0;
        alloc_idx = '0;
        for (int i = CAP - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                ready     = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign free_hit = bitmap[free_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap <= '0;
            count  <= '0;
        end else begin
            if (alloc_en) bitmap[alloc_idx] <= 1'b1;
            if (free_en)  bitmap[free_idx]  <= 1'b0;
            case ({alloc_en, free_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opcode_tag_allocator.sv
// Per-opcode-type tag allocator with encoded tags, release decode and error pulses.
// Response and error pulses follow the accepting/releasing edge by one cycle.
// alloc_ready gates requests per type; the response path has no backpressure.
module opcode_tag_allocator
    import opcode_tag_allocator_pkg::*;
#(
    parameter int       NUM_TYPES = NUM_TYPES_DEF,
    parameter int       TAG_W     = TAG_W_DEF,
    parameter int       MAX_TAGS  = MAX_TAGS_DEF,
    parameter enc_tbl_t ENC_VALUE = ENC_VALUE_DEF,
    parameter enc_tbl_t ENC_MASK  = ENC_MASK_DEF,
    localparam int      TYPE_W    = $clog2(NUM_TYPES),
    localparam int      CNT_W     = $clog2(MAX_TAGS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [TYPE_W-1:0]          alloc_type,
    output logic                       alloc_ready,
    output logic                       rsp_valid,
    output logic [TAG_W-1:0]           rsp_tag,
    input  logic                       free_valid,
    input  logic [TAG_W-1:0]           free_tag,
    output logic                       err_double_free,
    output logic                       err_bad_tag,
    output logic [NUM_TYPES*CNT_W-1:0] outstanding
);

    localparam int IDX_W = $clog2(MAX_TAGS);

    logic [NUM_TYPES-1:0] pool_ready;
    logic [NUM_TYPES-1:0] pool_hit;
    logic [NUM_TYPES-1:0] alloc_en;
    logic [NUM_TYPES-1:0] free_en;
    logic [IDX_W-1:0]     pool_idx [NUM_TYPES];
    logic [TAG_W-1:0]     alloc_tag;
    logic                 accept;
    logic                 free_ok;
    logic                 free_dbl;
    logic                 free_bad;
    dec_t                 dec;

    assign dec = decode_tag(free_tag, ENC_VALUE, ENC_MASK);

    // Out-of-range alloc_type matches no pool and so reads as not ready.
    always_comb begin
        alloc_ready = 1'b0;
        alloc_tag   = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (alloc_type == TYPE_W'(t)) begin
                alloc_ready = pool_ready[t];
                alloc_tag   = ENC_VALUE[t] | TAG_W'(pool_idx[t]);
            end
        end
    end

    assign accept = alloc_valid & alloc_ready;

    always_comb begin
        free_ok  = 1'b0;
        free_dbl = 1'b0;
        free_bad = 1'b1;
        if (dec.hit) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                if (int'(dec.typ) == t && int'(dec.idx) < pool_cap(ENC_MASK[t], MAX_TAGS)) begin
                    free_bad = 1'b0;
                    free_ok  = pool_hit[t];
                    free_dbl = ~pool_hit[t];
                end
            end
        end
    end

    for (genvar t = 0; t < NUM_TYPES; t++) begin : g_pool
        assign alloc_en[t] = accept & (alloc_type == TYPE_W'(t));
        assign free_en[t]  = free_valid & free_ok & (int'(dec.typ) == t);

        opcode_tag_allocator_tag_pool #(
            .MAX_TAGS (MAX_TAGS),
            .CAP      (pool_cap(ENC_MASK[t], MAX_TAGS)),
            .IDX_W    (IDX_W),
            .CNT_W    (CNT_W)
        ) u_tag_pool (
            .clk       (clk),
            .rst       (rst),
            .alloc_en  (alloc_en[t]),
            .free_en   (free_en[t]),
            .free_idx  (dec.idx[IDX_W-1:0]),
            .ready     (pool_ready[t]),
            .alloc_idx (pool_idx[t]),
            .free_hit  (pool_hit[t]),
            .count     (outstanding[t*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid       <= 1'b0;
            rsp_tag         <= '0;
            err_double_free <= 1'b0;
            err_bad_tag     <= 1'b0;
        end else begin
            rsp_valid       <= accept;
            if (accept) rsp_tag <= alloc_tag;
            err_double_free <= free_valid & free_dbl;
            err_bad_tag     <= free_valid & free_bad;
        end
    end

endmodule

// File: tb/tb_opcode_tag_allocator.sv
// Directed bench for opcode_tag_allocator: allocation order, release decode, errors and reset.
module tb_opcode_tag_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [2:0]  alloc_type = 3'd0;
    logic        alloc_ready;
    logic        rsp_valid;
    logic [8:0]  rsp_tag;
    logic        free_valid = 1'b0;
    logic [8:0]  free_tag = 9'h000;
    logic        err_double_free;
    logic        err_bad_tag;
    logic [34:0] outstanding;

    int checks = 0;
    int failures = 0;
    logic watch = 1'b0;
    logic saw_rsp = 1'b0;

    opcode_tag_allocator dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_type      (alloc_type),
        .alloc_ready     (alloc_ready),
        .rsp_valid       (rsp_valid),
        .rsp_tag         (rsp_tag),
        .free_valid      (free_valid),
        .free_tag        (free_tag),
        .err_double_free (err_double_free),
        .err_bad_tag     (err_bad_tag),
        .outstanding     (outstanding)
    );

    always #5 clk = ~clk;

    always @(posedge rsp_valid) if (watch) saw_rsp = 1'b1;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs(input int t);
        return outstanding[t*7 +: 7];
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_err_dbl", err_double_free, 0);
        chk("rst_err_bad", err_bad_tag, 0);
        chk("rst_outstanding", outstanding, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int t = 0; t < 5; t++) begin
            alloc_type = 3'(t);
            #1 chk($sformatf("ready_after_rst_t%0d", t), alloc_ready, 1);
        end
        alloc_type = 3'd5;
        #1 chk("ready_type5", alloc_ready, 0);
        alloc_type = 3'd7;
        #1 chk("ready_type7", alloc_ready, 0);

        // Type 1 allocated three times in a row
        alloc_valid = 1'b1;
        alloc_type  = 3'd1;
        step();
        chk("t1_rsp0_vld", rsp_valid, 1);
        chk("t1_rsp0_tag", rsp_tag, 9'h040);
        step();
        chk("t1_rsp1_vld", rsp_valid, 1);
        chk("t1_rsp1_tag", rsp_tag, 9'h041);
        step();
        chk("t1_rsp2_vld", rsp_valid, 1);
        chk("t1_rsp2_tag", rsp_tag, 9'h042);
        chk("t1_out3", outs(1), 3);
        alloc_valid = 1'b0;
        step();
        chk("t1_rsp_idle", rsp_valid, 0);

        // Type 4 pool of two: exhaust, free, re-allocate
        alloc_valid = 1'b1;
        alloc_type  = 3'd4;
        step();
        chk("t4_rsp0_tag", rsp_tag, 9'h100);
        step();
        chk("t4_rsp1_tag", rsp_tag, 9'h101);
        alloc_valid = 1'b0;
        #1 chk("t4_full_ready", alloc_ready, 0);
        chk("t4_out2", outs(4), 2);
        free_valid = 1'b1;
        free_tag   = 9'h100;
        #1 chk("t4_ready_same_cycle_as_free", alloc_ready, 0);
        step();
        free_valid = 1'b0;
        #1 chk("t4_ready_after_free", alloc_ready, 1);
        chk("t4_out1", outs(4), 1);
        chk("t4_free_no_err", {err_double_free, err_bad_tag}, 0);
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        chk("t4_realloc_vld", rsp_valid, 1);
        chk("t4_realloc_tag", rsp_tag, 9'h100);
        step();

        // Release of a never-allocated tag
        free_valid = 1'b1;
        free_tag   = 9'h045;
        step();
        free_valid = 1'b0;
        chk("dbl_free_pulse", err_double_free, 1);
        chk("dbl_free_no_bad", err_bad_tag, 0);
        chk("dbl_free_out1", outs(1), 3);
        step();
        chk("dbl_free_pulse_end", err_double_free, 0);

        // Tag matching no type
        free_valid = 1'b1;
        free_tag   = 9'h1c0;
        step();
        free_valid = 1'b0;
        chk("bad_tag_pulse", err_bad_tag, 1);
        chk("bad_tag_no_dbl", err_double_free, 0);
        chk("bad_tag_state", outstanding, (35'd2 << 28) | (35'd3 << 7));
        step();
        chk("bad_tag_pulse_end", err_bad_tag, 0);

        // Same-type accept and release in one cycle: net count unchanged
        alloc_valid = 1'b1;
        alloc_type  = 3'd1;
        free_valid  = 1'b1;
        free_tag    = 9'h041;
        step();
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
        chk("simul_rsp_tag", rsp_tag, 9'h043);
        chk("simul_out1", outs(1), 3);
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        chk("refill_lowest_tag", rsp_tag, 9'h041);
        chk("refill_out1", outs(1), 4);

        // Fill type 0, then allocate and release on the full pool together
        alloc_valid = 1'b1;
        alloc_type  = 3'd0;
        for (int i = 0; i < 64; i++) begin
            step();
            chk($sformatf("t0_fill_%0d", i), rsp_tag, 9'(i));
        end
        free_valid = 1'b1;
        free_tag   = 9'h000;
        #1 chk("t0_full_ready", alloc_ready, 0);
        step();
        free_valid = 1'b0;
        chk("t0_no_accept_when_full", rsp_valid, 0);
        chk("t0_out63", outs(0), 63);
        step();
        alloc_valid = 1'b0;
        chk("t0_accept_after_free_vld", rsp_valid, 1);
        chk("t0_accept_after_free_tag", rsp_tag, 9'h000);
        chk("t0_out64", outs(0), 64);
        step();

        // Reset while an accept is in flight
        watch       = 1'b1;
        alloc_valid = 1'b1;
        alloc_type  = 3'd2;
        #3 rst = 1'b1;
        #1 alloc_valid = 1'b0;
        step();
        chk("rst_pending_rsp_valid", rsp_valid, 0);
        step();
        chk("rst_pending_out", outstanding, 0);
        chk("rst_pending_rsp_tag", rsp_tag, 0);
        chk("rst_pending_errs", {err_double_free, err_bad_tag}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            alloc_type = 3'(t);
            #1 chk($sformatf("ready_after_rst2_t%0d", t), alloc_ready, 1);
        end
        step();
        step();
        chk("rst_no_late_rsp", rsp_valid, 0);
        chk("rst_never_pulsed", saw_rsp, 0);
        watch = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opcode_tag_allocator.md
OPCODE_TAG_ALLOCATOR -- requirements
Module: opcode_tag_allocator

Interface
REQ-001 Parameter NUM_TYPES, 5, number of opcode types.
REQ-002 Parameter TAG_W, 9, encoded tag width.
REQ-003 Parameter MAX_TAGS, 64, per-type pool depth (power of 2).
REQ-004 Parameter ENC_VALUE, {9'h000,9'h040,9'h080,9'h0c0,9'h100}, per-type encoding value.
REQ-005 Parameter ENC_MASK, {9'h1c0,9'h1c0,9'h1c0,9'h1c0,9'h1fe}, per-type encoding mask; zero bits are contiguous from bit 0.
REQ-006 clk  in  1  single clock; all state is on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 alloc_valid  in  1  allocation request.
REQ-009 alloc_type  in  clog2(NUM_TYPES)  requested opcode type.
REQ-010 alloc_ready  out  1  requested type has a free tag.
REQ-011 rsp_valid  out  1  encoded tag valid, one-cycle pulse.
REQ-012 rsp_tag  out  TAG_W  encoded allocated tag.
REQ-013 free_valid  in  1  tag release.
REQ-014 free_tag  in  TAG_W  encoded tag being released.
REQ-015 err_double_free  out  1  one-cycle pulse: released tag was not outstanding.
REQ-016 err_bad_tag  out  1  one-cycle pulse: free_tag matches no type or exceeds capacity.
REQ-017 outstanding  out  NUM_TYPES*clog2(MAX_TAGS+1)  per-type in-use count.

Function
REQ-018 Per-type capacity = min(2^(zero bits in ENC_MASK[t]), MAX_TAGS); defaults give 64,64,64,64,2.
REQ-019 Per-type in-use bitmap of MAX_TAGS bits; bits at or above capacity are never set.
REQ-020 alloc_ready is combinational from alloc_type: high when the type's bitmap has a zero below capacity.
REQ-021 Accept = alloc_valid & alloc_ready; on accept the lowest free index is set in the bitmap.
REQ-022 Latency 1: the cycle after accept rsp_valid=1, rsp_tag = ENC_VALUE[type] | index; no backpressure on the response.
REQ-023 One accept per cycle maximum; back-to-back accepts yield one response per cycle.
REQ-024 alloc_type out of range (>= NUM_TYPES) drives alloc_ready=0.
REQ-025 Free decode: type = lowest t with (free_tag & ENC_MASK[t]) == ENC_VALUE[t]; index = free_tag & ~ENC_MASK[t].
REQ-026 No matching type, or index >= capacity: no state change; err_bad_tag pulses the next cycle.
REQ-027 Index not set: no state change; err_double_free pulses the next cycle.
REQ-028 Valid free clears the bit at the clock edge; a tag freed in cycle N is allocatable from cycle N+1, never in cycle N.
REQ-029 Simultaneous accept and free on the same type both take effect; the count changes by 0.
REQ-030 outstanding[t] is a registered popcount; it equals bitmap population after every edge.
REQ-031 Pool full then a free: alloc_ready rises the next cycle.

Reset
REQ-032 rst asserted clears all bitmaps and counts; rsp_valid=0, rsp_tag=0, both err outputs 0, asynchronously.
REQ-033 A response pending when reset asserts is dropped; no post-reset pulse.
REQ-034 After deassertion every type reports alloc_ready=1.

Structure
REQ-035 The shared package holds the opcode type enum, tag typedef, and default ENC_VALUE/ENC_MASK tables, so encoders and this block share one definition.
REQ-036 Sub-module tag_pool (one per type, generate loop) holds bitmap, find-first-zero, set/clear, and count.
REQ-037 Decode is a package function shared with software-model-generated encoders.

Verification
REQ-038 After reset, allocate type 1 three times -> rsp_tag 9'h040, 9'h041, 9'h042 on consecutive cycles; outstanding[1]=3.
REQ-039 Allocate type 4 twice -> 9'h100, 9'h101; alloc_ready for type 4 drops; free 9'h100 -> ready the next cycle; re-allocate returns 9'h100.
REQ-040 Free 9'h045 (never allocated) -> err_double_free pulse; outstanding unchanged.
REQ-041 Free 9'h1c0 (matches no type) -> err_bad_tag pulse; no state change.
REQ-042 Same cycle: alloc type 0 and free 9'h000 of a full type-0 pool -> no accept in that cycle; accept the next cycle returns 9'h000.
REQ-043 Assert rst the cycle after an accept -> rsp_valid never pulses; all outstanding=0; all types ready.
